// File: rtl/rpn_pkg.sv
// Shared types and helpers for the RPN calculator operand stack.
// Default sizes, opcode and FSM state enums, and the overflow range check.
package rpn_pkg;

  localparam int unsigned RPN_WIDTH = 8;
  localparam int unsigned RPN_DEPTH = 4;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_ADD,
    OP_SUB,
    OP_MUL
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    WB
  } state_e;

  // True when a full-precision result is representable as a width-bit signed value.
  function automatic logic fits(input longint value, input int unsigned width);
    longint lim;
    lim = longint'(1) <<< (width - 1);
    return (value >= -lim) && (value <= lim - 1);
  endfunction

endpackage

// File: rtl/rpn_stack_if.sv
// Command/result bundle between the button front-end, the stack engine and the display.
// master drives operand and command pulses; slave is the stack engine.
interface rpn_stack_if #(
  parameter int unsigned WIDTH = rpn_pkg::RPN_WIDTH,
  parameter int unsigned DEPTH = rpn_pkg::RPN_DEPTH
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] operand;
  logic             push;
  logic             pop;
  logic             add;
  logic             sub;
  logic             mul;
  logic [WIDTH-1:0] top;
  logic             topValid;
  logic [CW-1:0]    count;
  logic             busy;
  logic             ovf;
  logic             err;

  modport master (
    output operand, push, pop, add, sub, mul,
    input  top, topValid, count, busy, ovf, err
  );

  modport slave (
    input  operand, push, pop, add, sub, mul,
    output top, topValid, count, busy, ovf, err
  );

endinterface

// File: rtl/rpn_alu.sv
// Combinational arithmetic for the RPN stack: add/sub with overflow detect,
// and a signed multiplier producing the full double-width product.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = RPN_WIDTH
) (
  input  logic signed [WIDTH-1:0]   a_i,
  input  logic signed [WIDTH-1:0]   b_i,
  input  logic                      sub_i,
  output logic signed [WIDTH-1:0]   sum_o,
  output logic                      sum_ovf_o,
  output logic signed [2*WIDTH-1:0] prod_o
);

  logic signed [WIDTH:0]     a_ext;
  logic signed [WIDTH:0]     b_ext;
  logic signed [WIDTH:0]     full;
  logic signed [2*WIDTH-1:0] a_wide;
  logic signed [2*WIDTH-1:0] b_wide;

  always_comb begin
    a_ext     = {a_i[WIDTH-1], a_i};
    b_ext     = {b_i[WIDTH-1], b_i};
    full      = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);
    sum_o     = full[WIDTH-1:0];
    sum_ovf_o = !fits(longint'(full), WIDTH);
  end

  always_comb begin
    a_wide = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    b_wide = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    prod_o = a_wide * b_wide;
  end

endmodule

// File: rtl/rpn_stack.sv
// RPN calculator operand stack: fixed-depth signed LIFO with add/sub/mul and
// sticky overflow/error flags. Multiply takes three cycles via MUL and WB states.
module rpn_stack
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = RPN_WIDTH,
  parameter int unsigned DEPTH = RPN_DEPTH
) (
  input logic        clock,
  input logic        resetN,
  rpn_stack_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [WIDTH-1:0]   entries_q [DEPTH];
  logic signed [WIDTH-1:0]   entries_d [DEPTH];
  logic [CW-1:0]             count_q, count_d;
  logic signed [2*WIDTH-1:0] prod_q, prod_d;
  logic                      ovf_q, ovf_d;
  logic                      err_q, err_d;
  logic signed [WIDTH-1:0]   top_q, top_d;
  logic                      top_valid_q, top_valid_d;
  state_e                    state_q, state_d;

  logic [4:0]                cmd;
  op_e                       op;
  logic                      any_cmd;
  logic                      one_hot;
  logic                      legal;

  logic [IW-1:0]             a_idx, b_idx, push_idx, top_idx;
  logic signed [WIDTH-1:0]   op_a, op_b, sum;
  logic                      sum_ovf;
  logic signed [2*WIDTH-1:0] prod;

  assign cmd     = {bus.push, bus.pop, bus.add, bus.sub, bus.mul};
  assign any_cmd = |cmd;
  assign one_hot = $onehot(cmd);

  always_comb begin
    op = OP_NONE;
    unique case (cmd)
      5'b10000: op = OP_PUSH;
      5'b01000: op = OP_POP;
      5'b00100: op = OP_ADD;
      5'b00010: op = OP_SUB;
      5'b00001: op = OP_MUL;
      default:  op = OP_NONE;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_PUSH:                legal = count_q < CW'(DEPTH);
      OP_POP:                 legal = count_q != '0;
      OP_ADD, OP_SUB, OP_MUL: legal = count_q >= CW'(2);
      default:                legal = 1'b0;
    endcase
  end

  // Indices wrap when count is too small; the result is only used when legal.
  always_comb begin
    a_idx    = IW'(count_q - CW'(2));
    b_idx    = IW'(count_q - CW'(1));
    push_idx = IW'(count_q);
    op_a     = entries_q[a_idx];
    op_b     = entries_q[b_idx];
  end

  rpn_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a_i      (op_a),
    .b_i      (op_b),
    .sub_i    (op == OP_SUB),
    .sum_o    (sum),
    .sum_ovf_o(sum_ovf),
    .prod_o   (prod)
  );

  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    prod_d    = prod_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    state_d   = state_q;

    case (state_q)
      IDLE: begin
        if (any_cmd) begin
          if (one_hot && legal) begin
            ovf_d = 1'b0;
            err_d = 1'b0;
            case (op)
              OP_PUSH: begin
                entries_d[push_idx] = bus.operand;
                count_d             = count_q + 1'b1;
              end
              OP_POP: count_d = count_q - 1'b1;
              OP_ADD, OP_SUB: begin
                entries_d[a_idx] = sum;
                count_d          = count_q - 1'b1;
                ovf_d            = sum_ovf;
              end
              OP_MUL:  state_d = MUL;
              default: ;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
      end
      MUL: begin
        prod_d  = prod;
        state_d = WB;
        if (any_cmd) err_d = 1'b1;
      end
      WB: begin
        entries_d[a_idx] = prod_q[WIDTH-1:0];
        count_d          = count_q - 1'b1;
        ovf_d            = !fits(longint'(prod_q), WIDTH);
        state_d          = IDLE;
        if (any_cmd) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Top of stack is registered, so derive it from the next-state array.
    top_idx     = IW'(count_d - CW'(1));
    top_valid_d = count_d != '0;
    top_d       = top_valid_d ? entries_d[top_idx] : '0;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < int'(DEPTH); i++) entries_q[i] <= '0;
      count_q     <= '0;
      prod_q      <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      top_q       <= '0;
      top_valid_q <= 1'b0;
      state_q     <= IDLE;
    end else begin
      entries_q   <= entries_d;
      count_q     <= count_d;
      prod_q      <= prod_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      top_q       <= top_d;
      top_valid_q <= top_valid_d;
      state_q     <= state_d;
    end
  end

  assign bus.top      = top_q;
  assign bus.topValid = top_valid_q;
  assign bus.count    = count_q;
  assign bus.busy     = state_q != IDLE;
  assign bus.ovf      = ovf_q;
  assign bus.err      = err_q;

endmodule
